// File: rtl/vliw_pkg.sv
// Shared constants for the VLIW register file: default geometry, read-port
// field indices within a slot, and the conflict counter width.
package vliw_pkg;
    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 8;

    localparam int PORT_M       = 0;
    localparam int PORT_N       = 1;
    localparam int PORT_D       = 2;
    localparam int NUM_RD_PORTS = 3;

    localparam int CNT_W        = 8;
endpackage

// File: rtl/vliw_wr_arbiter.sv
// Write arbitration for one architectural register: the lowest enabled slot
// targeting REG_IDX wins, and two or more hits flag a conflict.
module vliw_wr_arbiter
    import vliw_pkg::*;
#(
    parameter int SLOTS   = 2,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = 3,
    parameter int REG_IDX = 1
) (
    input  logic [SLOTS-1:0]        wr_en,
    input  logic [SLOTS*ADDR_W-1:0] wr_addr,
    input  logic [SLOTS*DATA_W-1:0] wr_data,
    output logic                    wrStrobe,
    output logic [DATA_W-1:0]       winData,
    output logic                    conflict
);
    logic [SLOTS-1:0] hit;

    always_comb begin
        hit = '0;
        for (int s = 0; s < SLOTS; s++) begin
            hit[s] = wr_en[s] && (wr_addr[s*ADDR_W +: ADDR_W] == ADDR_W'(REG_IDX));
        end
        wrStrobe = |hit;
        // Walk from the top slot down so the lowest-indexed hit is assigned last.
        winData = '0;
        for (int s = SLOTS - 1; s >= 0; s--) begin
            if (hit[s]) winData = wr_data[s*DATA_W +: DATA_W];
        end
        conflict = (hit & (hit - SLOTS'(1))) != '0;
    end
endmodule

// File: rtl/vliw_regfile.sv
// Multi-slot register file with optional write-to-read bypass, a pending-write
// scoreboard and same-cycle write-conflict detection. Register 0 reads as zero.
module vliw_regfile
    import vliw_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int SLOTS    = 2,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS),
    localparam int NRD     = SLOTS * NUM_RD_PORTS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NRD*ADDR_W-1:0]   rd_addr,
    output logic [NRD*DATA_W-1:0]   rd_data,
    input  logic [SLOTS-1:0]        wr_en,
    input  logic [SLOTS*ADDR_W-1:0] wr_addr,
    input  logic [SLOTS*DATA_W-1:0] wr_data,
    input  logic [SLOTS-1:0]        sb_set,
    input  logic [SLOTS*ADDR_W-1:0] sb_addr,
    output logic [NUM_REGS-1:0]     busy,
    output logic                    wr_conflict,
    output logic [CNT_W-1:0]        conflict_cnt
);
    // No handshake: every input is sampled on every rising edge while reset is
    // low, and the block never stalls; consumers consult busy themselves.

    logic [DATA_W-1:0]   regArray [NUM_REGS];
    logic [NUM_REGS-1:0] wrStrobe;
    logic [DATA_W-1:0]   winData [NUM_REGS];
    logic [NUM_REGS-1:0] conflictVec;
    logic [NUM_REGS-1:0] busyNext;
    logic                anyConflict;

    assign wrStrobe[0]    = 1'b0;
    assign winData[0]     = '0;
    assign conflictVec[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : gen_arb
        vliw_wr_arbiter #(
            .SLOTS  (SLOTS),
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .REG_IDX(r)
        ) u_arb (
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .wrStrobe(wrStrobe[r]),
            .winData (winData[r]),
            .conflict(conflictVec[r])
        );
    end

    assign anyConflict = |conflictVec;

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            logic [ADDR_W-1:0] a;
            a = rd_addr[i*ADDR_W +: ADDR_W];
            if (a == '0) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
            end else if ((BYPASS != 0) && wrStrobe[a]) begin
                rd_data[i*DATA_W +: DATA_W] = winData[a];
            end else begin
                rd_data[i*DATA_W +: DATA_W] = regArray[a];
            end
        end
    end

    // A set in the same cycle as a write wins: a newer long-latency op is pending.
    always_comb begin
        busyNext = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            logic setHit;
            setHit = 1'b0;
            for (int s = 0; s < SLOTS; s++) begin
                if (sb_set[s] && (sb_addr[s*ADDR_W +: ADDR_W] == ADDR_W'(r))) setHit = 1'b1;
            end
            busyNext[r] = setHit | (busy[r] & ~wrStrobe[r]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) regArray[r] <= '0;
            busy         <= '0;
            wr_conflict  <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (wrStrobe[r]) regArray[r] <= winData[r];
            end
            busy        <= busyNext;
            wr_conflict <= anyConflict;
            if (anyConflict && (conflict_cnt != {CNT_W{1'b1}})) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end
endmodule
